// File: rtl/ascii_hex_loader.sv
// Parses "AAAA=DD<CR|LF>" ASCII lines into address/data write strobes.
// Malformed lines raise a single err pulse and never disturb TestAd/TestDat.
module ascii_hex_loader #(
  parameter int ADDR_DIGITS = 4,
  parameter int DATA_DIGITS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic [4*ADDR_DIGITS-1:0]   TestAd,
  output logic [4*DATA_DIGITS-1:0]   TestDat,
  output logic                       wr_en,
  output logic                       err,
  output logic                       busy,
  output logic [7:0]                 wr_count
);

  localparam int AW   = 4 * ADDR_DIGITS;
  localparam int DW   = 4 * DATA_DIGITS;
  localparam int MAXD = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
  localparam int CW   = $clog2(MAXD + 1);
  localparam logic [CW-1:0] ADDR_CNT = CW'(ADDR_DIGITS);
  localparam logic [CW-1:0] DATA_CNT = CW'(DATA_DIGITS);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, SKIP} state_t;

  state_t          state, state_n;
  logic [AW-1:0]   addr_sr;
  logic [DW-1:0]   data_sr;
  logic [CW-1:0]   cnt, cnt_n;

  logic            is_hex, is_term, is_eq;
  logic [3:0]      nib;
  logic            load_addr, shift_addr, shift_data, clr_data, commit, err_n;

  always_comb begin
    is_hex = 1'b0;
    nib    = '0;
    if (rx_data inside {[8'h30:8'h39]}) begin
      is_hex = 1'b1;
      nib    = rx_data[3:0];
    end else if (rx_data inside {[8'h41:8'h46], [8'h61:8'h66]}) begin
      is_hex = 1'b1;
      nib    = rx_data[3:0] + 4'd9;
    end
    is_term = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    is_eq   = (rx_data == 8'h3D);
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    load_addr  = 1'b0;
    shift_addr = 1'b0;
    shift_data = 1'b0;
    clr_data   = 1'b0;
    commit     = 1'b0;
    err_n      = 1'b0;
    if (rx_valid) begin
      unique case (state)
        IDLE: begin
          if (is_hex) begin
            load_addr = 1'b1;
            cnt_n     = CW'(1);
            state_n   = ADDR;
          end else if (!is_term) begin
            err_n   = 1'b1;
            state_n = SKIP;
          end
        end
        ADDR: begin
          if (is_hex && cnt < ADDR_CNT) begin
            shift_addr = 1'b1;
            cnt_n      = cnt + CW'(1);
          end else if (is_eq && cnt == ADDR_CNT) begin
            cnt_n    = '0;
            clr_data = 1'b1;
            state_n  = DATA;
          end else begin
            // an early terminator already ends the line, so skip straight to IDLE
            err_n   = 1'b1;
            state_n = is_term ? IDLE : SKIP;
          end
        end
        DATA: begin
          if (is_hex && cnt < DATA_CNT) begin
            shift_data = 1'b1;
            cnt_n      = cnt + CW'(1);
          end else if (is_term && cnt == DATA_CNT) begin
            commit  = 1'b1;
            state_n = IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = is_term ? IDLE : SKIP;
          end
        end
        SKIP: begin
          if (is_term) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
      wr_en <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      busy  <= (state_n != IDLE);
      err   <= err_n;
      wr_en <= commit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_sr  <= '0;
      data_sr  <= '0;
      TestAd   <= '0;
      TestDat  <= '0;
      wr_count <= '0;
    end else begin
      if (load_addr)       addr_sr <= AW'(nib);
      else if (shift_addr) addr_sr <= AW'({addr_sr, nib});
      if (clr_data)        data_sr <= '0;
      else if (shift_data) data_sr <= DW'({data_sr, nib});
      if (commit) begin
        TestAd   <= addr_sr;
        TestDat  <= data_sr;
        wr_count <= wr_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ascii_hex_loader.sv
// Randomized bench for ascii_hex_loader against a line-level reference model.
module tb_ascii_hex_loader;

  localparam int A = 4;
  localparam int D = 2;
  localparam byte unsigned CR = 8'h0D;
  localparam byte unsigned LF = 8'h0A;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = '0;
  logic [15:0]  TestAd;
  logic [7:0]   TestDat;
  logic         wr_en, err, busy;
  logic [7:0]   wr_count;

  ascii_hex_loader #(.ADDR_DIGITS(A), .DATA_DIGITS(D)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .TestAd(TestAd), .TestDat(TestDat), .wr_en(wr_en), .err(err),
    .busy(busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: the text of the current line and whether it is being discarded
  byte unsigned line[$];
  bit           skipping;
  logic [15:0]  m_ad;
  logic [7:0]   m_dat;
  logic [7:0]   m_cnt;
  bit           m_wr, m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_hex(input byte unsigned c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic bit is_term(input byte unsigned c);
    return c == CR || c == LF;
  endfunction

  function automatic int hexval(input byte unsigned c);
    if (c >= "0" && c <= "9") return c - "0";
    if (c >= "A" && c <= "F") return c - "A" + 10;
    return c - "a" + 10;
  endfunction

  // character class expected at position p of "AAAA=DD"
  function automatic bit char_ok(input byte unsigned c, input int p);
    return (p == A) ? (c == "=") : is_hex(c);
  endfunction

  task automatic model_reset();
    line.delete();
    skipping = 0;
    m_ad = '0; m_dat = '0; m_cnt = '0; m_wr = 0; m_err = 0;
  endtask

  task automatic model_byte(input byte unsigned c);
    int unsigned v;
    if (skipping) begin
      if (is_term(c)) skipping = 0;
    end else if (is_term(c)) begin
      if (line.size() == A + D + 1) begin
        v = 0;
        for (int i = 0; i < A; i++) v = v * 16 + hexval(line[i]);
        m_ad = 16'(v);
        v = 0;
        for (int i = A + 1; i < A + D + 1; i++) v = v * 16 + hexval(line[i]);
        m_dat = 8'(v);
        m_cnt = m_cnt + 8'd1;
        m_wr  = 1;
      end else if (line.size() != 0) begin
        m_err = 1;
      end
      line.delete();
    end else if (line.size() < A + D + 1 && char_ok(c, line.size())) begin
      line.push_back(c);
    end else begin
      m_err = 1;
      skipping = 1;
      line.delete();
    end
  endtask

  task automatic check_all();
    check_eq("wr_en",    wr_en,    m_wr);
    check_eq("err",      err,      m_err);
    check_eq("busy",     busy,     (line.size() != 0) || skipping);
    check_eq("TestAd",   TestAd,   m_ad);
    check_eq("TestDat",  TestDat,  m_dat);
    check_eq("wr_count", wr_count, m_cnt);
  endtask

  task automatic step(input bit v, input byte unsigned c);
    @(negedge clk);
    rx_valid = v;
    rx_data  = v ? c : 8'($urandom);
    @(posedge clk);
    m_wr = 0;
    m_err = 0;
    if (v) model_byte(c);
    #1 check_all();
  endtask

  task automatic gaps(input int max_gap);
    int n;
    n = $urandom_range(0, max_gap);
    for (int i = 0; i < n; i++) step(0, 8'h00);
  endtask

  task automatic send_str(input string s, input int max_gap);
    for (int i = 0; i < s.len(); i++) begin
      step(1, s[i]);
      if (i != s.len() - 1) gaps(max_gap);
    end
  endtask

  task automatic send_q(input byte unsigned q[$], input int max_gap);
    foreach (q[i]) begin
      step(1, q[i]);
      gaps(max_gap);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic byte unsigned rand_hex();
    string hs;
    hs = "0123456789ABCDEFabcdef";
    return hs[$urandom_range(0, 21)];
  endfunction

  task automatic gen_line(input bit good, output byte unsigned q[$]);
    string junk;
    int p;
    junk = "Gx= z:";
    q.delete();
    for (int i = 0; i < A; i++) q.push_back(rand_hex());
    q.push_back("=");
    for (int i = 0; i < D; i++) q.push_back(rand_hex());
    if (!good) begin
      p = $urandom_range(0, A + D);
      case ($urandom_range(0, 3))
        0: q[p] = junk[$urandom_range(0, 5)];
        1: q.delete(p);
        2: q.insert(p, rand_hex());
        default: q.insert(p, is_term(CR) ? (($urandom_range(0, 1) != 0) ? CR : LF) : LF);
      endcase
    end
    case ($urandom_range(0, 2))
      0: q.push_back(CR);
      1: q.push_back(LF);
      default: begin q.push_back(CR); q.push_back(LF); end
    endcase
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte unsigned q[$];
    model_reset();
    #1 check_all();
    #12 rst = 1'b1;

    send_str("1A2F=C3\015", 0);
    check_eq("ex1_wr",  wr_en,    1);
    check_eq("ex1_ad",  TestAd,   16'h1A2F);
    check_eq("ex1_dat", TestDat,  8'hC3);
    check_eq("ex1_cnt", wr_count, 8'd1);
    step(0, 8'h00);
    check_eq("ex1_pulse", wr_en, 0);

    send_str("00ff=7e\015\0120010=01\012", 2);
    check_eq("ex2_ad",  TestAd,   16'h0010);
    check_eq("ex2_dat", TestDat,  8'h01);
    check_eq("ex2_cnt", wr_count, 8'd3);

    send_str("12G", 0);
    check_eq("ex3_err", err, 1);
    send_str("4=55\015", 1);
    check_eq("ex3_ad",  TestAd,   16'h0010);
    check_eq("ex3_cnt", wr_count, 8'd3);
    send_str("BEEF=99\012", 0);
    check_eq("ex3_next", TestAd, 16'hBEEF);

    send_str("123=45\012", 0);
    send_str("1234=5\012", 0);
    check_eq("ex4_err", err, 1);
    send_str("\015\012\015\012", 1);
    check_eq("ex4_cnt", wr_count, 8'd4);

    send_str("AB", 3);
    check_eq("ex5_busy", busy, 1);
    do_reset();
    send_str("0001=02\012", 0);
    check_eq("ex5_ad",  TestAd,   16'h0001);
    check_eq("ex5_dat", TestDat,  8'h02);
    check_eq("ex5_cnt", wr_count, 8'd1);

    for (int i = 0; i < 300; i++) begin
      gen_line($urandom_range(0, 2) != 0, q);
      send_q(q, ($urandom_range(0, 3) == 0) ? 2 : 0);
    end

    do_reset();
    for (int i = 0; i < 256; i++) begin
      gen_line(1'b1, q);
      send_q(q, 0);
      gaps(3);
    end
    check_eq("wrap_cnt", wr_count, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
